// File: rtl/elevator_pkg.sv
// Shared elevator types: floor widths, scheduler states, scan direction constants
// and the SCAN target-selection helpers.
package elevator_pkg;

    localparam int unsigned FLOOR_W    = 2;
    localparam int unsigned NUM_FLOORS = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        OFFER  = 2'd2,
        TRAVEL = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic               found;
        logic [FLOOR_W-1:0] target_floor;
        logic               up;
    } target_t;

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] oh;
        oh    = '0;
        oh[f] = 1'b1;
        return oh;
    endfunction

    // SCAN pick: nearest stop ahead, else reverse to nearest stop behind, else the current floor.
    function automatic target_t pick_target(input logic [NUM_FLOORS-1:0] pend,
                                            input logic [FLOOR_W-1:0]    cf,
                                            input logic                  up);
        target_t            t;
        logic               a_found;
        logic               b_found;
        logic [FLOOR_W-1:0] a_fl;
        logic [FLOOR_W-1:0] b_fl;
        a_found = 1'b0;
        b_found = 1'b0;
        a_fl    = '0;
        b_fl    = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pend[i] && (FLOOR_W'(i) > cf)) begin
                a_found = 1'b1;
                a_fl    = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend[i] && (FLOOR_W'(i) < cf)) begin
                b_found = 1'b1;
                b_fl    = FLOOR_W'(i);
            end
        end
        t.found        = 1'b0;
        t.target_floor = cf;
        t.up           = up;
        if (up == DIR_UP) begin
            if (a_found) begin
                t.found = 1'b1; t.target_floor = a_fl; t.up = DIR_UP;
            end else if (b_found) begin
                t.found = 1'b1; t.target_floor = b_fl; t.up = DIR_DOWN;
            end
        end else begin
            if (b_found) begin
                t.found = 1'b1; t.target_floor = b_fl; t.up = DIR_DOWN;
            end else if (a_found) begin
                t.found = 1'b1; t.target_floor = a_fl; t.up = DIR_UP;
            end
        end
        if (!t.found && pend[cf]) begin
            t.found = 1'b1;
        end
        return t;
    endfunction

    // True when a pending stop lies strictly between the car and the offered target.
    function automatic logic in_scan_window(input logic [NUM_FLOORS-1:0] pend,
                                            input logic [FLOOR_W-1:0]    cf,
                                            input logic [FLOOR_W-1:0]    tgt,
                                            input logic                  up);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend[i]) begin
                if (up == DIR_UP) begin
                    hit = hit | ((FLOOR_W'(i) > cf) && (FLOOR_W'(i) < tgt));
                end else begin
                    hit = hit | ((FLOOR_W'(i) < cf) && (FLOOR_W'(i) > tgt));
                end
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/floor_request_scheduler_if.sv
// Target-floor handshake between the request scheduler and the elevator FSM.
interface floor_request_scheduler_if
    import elevator_pkg::*;
();
    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_ack;
    logic [FLOOR_W-1:0] current_floor;
    logic               arrived;

    modport master (
        output req_valid,
        output req_floor,
        input  req_ack,
        input  current_floor,
        input  arrived
    );

    modport slave (
        input  req_valid,
        input  req_floor,
        output req_ack,
        output current_floor,
        output arrived
    );
endinterface

// File: rtl/btn_debounce.sv
// One car button: 2-flop synchronizer, hold-time debounce, registered rise pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic             sync_meta;
    logic             sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // A new level is accepted only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            stable    <= 1'b0;
            cnt       <= '0;
            rise      <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync      <= sync_meta;
            rise      <= 1'b0;
            if (sync != stable) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync;
                    cnt    <= '0;
                    rise   <= sync;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/floor_request_scheduler.sv
// Latches debounced car-button presses as pending stops and offers the next
// SCAN target floor to the elevator FSM over a valid/ack handshake.
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_FLOORS-1:0]      btn,
    floor_request_scheduler_if.master  bus,
    output logic                       dir_up,
    output logic [NUM_FLOORS-1:0]      pending,
    output logic                       busy
);

    sched_state_e          state;
    sched_state_e          state_next;
    logic [NUM_FLOORS-1:0] rise;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic [NUM_FLOORS-1:0] pending_next;
    logic [FLOOR_W-1:0]    req_floor_q;
    logic [FLOOR_W-1:0]    req_floor_next;
    logic                  req_valid_q;
    logic                  dir_next;
    target_t               sel;

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk),
            .rst_n (reset),
            .btn   (btn[i]),
            .rise  (rise[i])
        );
    end

    assign bus.req_valid = req_valid_q;
    assign bus.req_floor = req_floor_q;

    // Next state, next target and pending update; a clear beats a same-cycle set.
    always_comb begin
        state_next     = state;
        req_floor_next = req_floor_q;
        dir_next       = dir_up;
        clr_mask       = bus.arrived ? floor_onehot(bus.current_floor) : '0;
        pending_next   = (pending | rise) & ~clr_mask;
        sel            = pick_target(pending, bus.current_floor, dir_up);
        unique case (state)
            IDLE: begin
                if (|pending) state_next = SELECT;
            end
            SELECT: begin
                if (sel.found) begin
                    state_next     = OFFER;
                    req_floor_next = sel.target_floor;
                    dir_next       = sel.up;
                end else begin
                    state_next = IDLE;
                end
            end
            OFFER: begin
                if (bus.req_ack) begin
                    state_next = TRAVEL;
                end else if (in_scan_window(pending, bus.current_floor, req_floor_q, dir_up)) begin
                    state_next = SELECT;
                end
            end
            TRAVEL: begin
                if (bus.arrived && (bus.current_floor == req_floor_q)) state_next = SELECT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pending     <= '0;
            dir_up      <= DIR_UP;
            req_floor_q <= '0;
            req_valid_q <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            dir_up      <= dir_next;
            req_floor_q <= req_floor_next;
            req_valid_q <= (state_next == OFFER);
            busy        <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed bench for floor_request_scheduler with a 4-cycle debounce.
module tb_floor_request_scheduler;
    import elevator_pkg::*;

    localparam int unsigned DB = 4;

    logic       clk;
    logic       reset;
    logic [3:0] btn;
    logic       dir_up;
    logic [3:0] pending;
    logic       busy;
    int         total;
    int         bad;

    floor_request_scheduler_if intf ();

    floor_request_scheduler #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn     (btn),
        .bus     (intf),
        .dir_up  (dir_up),
        .pending (pending),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cf;
        logic [3:0] mask;
        logic [1:0] exp_floor;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset              = 1'b0;
        btn                = '0;
        intf.req_ack       = 1'b0;
        intf.arrived       = 1'b0;
        intf.current_floor = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!intf.req_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic ack_and_arrive(input logic [1:0] f);
        intf.req_ack = 1'b1;
        tick();
        intf.req_ack       = 1'b0;
        intf.current_floor = f;
        intf.arrived       = 1'b1;
        tick();
        intf.arrived = 1'b0;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        vecs[0] = '{cf: 2'd0, mask: 4'b1000, exp_floor: 2'd3, exp_dir: 1'b1};
        vecs[1] = '{cf: 2'd1, mask: 4'b0101, exp_floor: 2'd2, exp_dir: 1'b1};
        vecs[2] = '{cf: 2'd2, mask: 4'b0011, exp_floor: 2'd1, exp_dir: 1'b0};
        vecs[3] = '{cf: 2'd3, mask: 4'b0001, exp_floor: 2'd0, exp_dir: 1'b0};
        vecs[4] = '{cf: 2'd2, mask: 4'b0100, exp_floor: 2'd2, exp_dir: 1'b1};
        vecs[5] = '{cf: 2'd1, mask: 4'b1101, exp_floor: 2'd2, exp_dir: 1'b1};
        vecs[6] = '{cf: 2'd3, mask: 4'b1010, exp_floor: 2'd1, exp_dir: 1'b0};
        vecs[7] = '{cf: 2'd0, mask: 4'b0001, exp_floor: 2'd0, exp_dir: 1'b1};

        // reset held with all buttons pressed
        reset              = 1'b0;
        btn                = 4'b1111;
        intf.req_ack       = 1'b0;
        intf.arrived       = 1'b0;
        intf.current_floor = '0;
        #2;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_valid", 8'(intf.req_valid), 8'd0);
        check("rst_floor", 8'(intf.req_floor), 8'd0);
        check("rst_dir", 8'(dir_up), 8'd1);
        check("rst_pending", 8'(pending), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        btn = '0;
        repeat (12) tick();
        check("rst_glitch_pending", 8'(pending), 8'd0);

        // 3-cycle glitch is rejected
        btn = 4'b0100;
        repeat (3) tick();
        btn = '0;
        repeat (12) tick();
        check("glitch_pending", 8'(pending), 8'd0);
        check("glitch_busy", 8'(busy), 8'd0);

        // held press latches after DB+3 edges, offer two edges later
        btn = 4'b0100;
        n = 0;
        while (!pending[2] && n < 20) begin
            tick();
            n++;
        end
        check("latch_latency", 8'(n), 8'(DB + 3));
        btn = '0;
        wait_valid(n);
        check("offer_latency", 8'(n), 8'd2);
        check("offer_floor", 8'(intf.req_floor), 8'd2);

        // SCAN selection table
        for (int k = 0; k < 8; k++) begin
            apply_reset();
            intf.current_floor = vecs[k].cf;
            btn                = vecs[k].mask;
            wait_valid(n);
            btn = '0;
            check($sformatf("vec%0d_latency", k), 8'(n), 8'(DB + 5));
            check($sformatf("vec%0d_floor", k), 8'(intf.req_floor), 8'(vecs[k].exp_floor));
            check($sformatf("vec%0d_dir", k), 8'(dir_up), 8'(vecs[k].exp_dir));
        end

        // basic service 0 -> 3
        apply_reset();
        btn = 4'b1000;
        wait_valid(n);
        btn = '0;
        check("basic_valid", 8'(intf.req_valid), 8'd1);
        check("basic_floor", 8'(intf.req_floor), 8'd3);
        check("basic_dir", 8'(dir_up), 8'd1);
        intf.req_ack = 1'b1;
        tick();
        intf.req_ack = 1'b0;
        check("basic_ack_valid", 8'(intf.req_valid), 8'd0);
        check("basic_travel_busy", 8'(busy), 8'd1);
        repeat (3) tick();
        check("basic_travel_hold", 8'(intf.req_valid), 8'd0);
        intf.current_floor = 2'd3;
        intf.arrived       = 1'b1;
        tick();
        intf.arrived = 1'b0;
        check("basic_arrive_pending", 8'(pending), 8'd0);
        check("basic_select_busy", 8'(busy), 8'd1);
        tick();
        check("basic_idle_busy", 8'(busy), 8'd0);

        // SCAN order from floor 1 with stops {0,2,3}
        apply_reset();
        intf.current_floor = 2'd1;
        btn                = 4'b1101;
        wait_valid(n);
        btn = '0;
        check("scan1_floor", 8'(intf.req_floor), 8'd2);
        check("scan1_dir", 8'(dir_up), 8'd1);
        ack_and_arrive(2'd2);
        wait_valid(n);
        check("scan2_floor", 8'(intf.req_floor), 8'd3);
        check("scan2_dir", 8'(dir_up), 8'd1);
        ack_and_arrive(2'd3);
        wait_valid(n);
        check("scan3_floor", 8'(intf.req_floor), 8'd0);
        check("scan3_dir", 8'(dir_up), 8'd0);
        ack_and_arrive(2'd0);
        tick();
        check("scan_done_pending", 8'(pending), 8'd0);
        check("scan_done_busy", 8'(busy), 8'd0);
        check("scan_done_dir", 8'(dir_up), 8'd0);

        // downward scan keeps going down, then reverses
        intf.current_floor = 2'd2;
        btn                = 4'b1010;
        wait_valid(n);
        btn = '0;
        check("down1_floor", 8'(intf.req_floor), 8'd1);
        check("down1_dir", 8'(dir_up), 8'd0);
        ack_and_arrive(2'd1);
        wait_valid(n);
        check("down2_floor", 8'(intf.req_floor), 8'd3);
        check("down2_dir", 8'(dir_up), 8'd1);

        // preemption while offering
        apply_reset();
        btn = 4'b1000;
        wait_valid(n);
        btn = 4'b0010;
        n   = 0;
        while (intf.req_valid && n < 20) begin
            tick();
            n++;
        end
        btn = '0;
        check("preempt_drop_edge", 8'(n), 8'(DB + 4));
        tick();
        check("preempt_revalid", 8'(intf.req_valid), 8'd1);
        check("preempt_floor", 8'(intf.req_floor), 8'd1);

        // presses after ack do not preempt; intermediate arrival clears its stop
        apply_reset();
        btn = 4'b1000;
        wait_valid(n);
        btn          = '0;
        intf.req_ack = 1'b1;
        tick();
        intf.req_ack = 1'b0;
        btn          = 4'b0110;
        repeat (DB + 6) tick();
        btn = '0;
        check("postack_valid", 8'(intf.req_valid), 8'd0);
        check("postack_pending", 8'(pending), 8'b1110);
        intf.current_floor = 2'd2;
        intf.arrived       = 1'b1;
        tick();
        intf.arrived = 1'b0;
        repeat (3) tick();
        check("inter_pending", 8'(pending), 8'b1010);
        check("inter_busy", 8'(busy), 8'd1);
        check("inter_valid", 8'(intf.req_valid), 8'd0);
        check("inter_floor", 8'(intf.req_floor), 8'd3);

        // set and clear on the same bit: clear wins
        apply_reset();
        intf.current_floor = 2'd1;
        btn                = 4'b0010;
        repeat (DB + 2) tick();
        intf.arrived = 1'b1;
        tick();
        intf.arrived = 1'b0;
        btn          = '0;
        check("setclr_pending", 8'(pending), 8'd0);
        repeat (3) tick();
        check("setclr_busy", 8'(busy), 8'd0);

        // asynchronous reset in TRAVEL
        apply_reset();
        btn = 4'b1100;
        wait_valid(n);
        btn          = '0;
        intf.req_ack = 1'b1;
        tick();
        intf.req_ack = 1'b0;
        check("pre_areset_busy", 8'(busy), 8'd1);
        check("pre_areset_pending", 8'(pending), 8'b1100);
        #2;
        reset = 1'b0;
        #1;
        check("areset_valid", 8'(intf.req_valid), 8'd0);
        check("areset_pending", 8'(pending), 8'd0);
        check("areset_busy", 8'(busy), 8'd0);
        tick();
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
